// File: rtl/chess_pkg.sv
// chess_pkg: shared state encoding and constants for the chess timer sequencer.
package chess_pkg;
  typedef enum logic [2:0] {
    SET    = 3'd0,
    READY  = 3'd1,
    RUN_P1 = 3'd2,
    RUN_P2 = 3'd3,
    PAUSE  = 3'd4,
    FLAG   = 3'd5
  } state_t;
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;
  localparam logic [7:0] MOVES_MAX = 8'd255;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle rising-edge strobe of an already synchronised input.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/chess_game_sequencer.sv
// chess_game_sequencer: set/ready/run/pause/flag sequencing, 1 Hz tick and time-out detect.
module chess_game_sequencer
  import chess_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned DEFAULT_MIN = 5,
  parameter int unsigned STEP_MIN    = 1,
  parameter int unsigned MAX_MIN     = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic       start,
  input  logic       add,
  input  logic [1:0] sw,
  input  logic [5:0] min1,
  input  logic [5:0] sec1,
  input  logic [5:0] min2,
  input  logic [5:0] sec2,
  output logic [5:0] min,
  output logic       load,
  output logic       tick,
  output logic       player1,
  output logic       player2,
  output logic       setTime,
  output logic [1:0] flag,
  output logic [7:0] moves
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t        state;
  logic          paused_p;
  logic [PW-1:0] presc;
  logic          set_r, start_r, add_r;
  logic [1:0]    sw_r;
  logic          run, zero, at_max;
  logic [6:0]    min_inc;
  logic [5:0]    min_nx;
  rise_detect u_set   (.clk(clk), .reset(reset), .d(set),   .rise(set_r));
  rise_detect u_start (.clk(clk), .reset(reset), .d(start), .rise(start_r));
  rise_detect u_add   (.clk(clk), .reset(reset), .d(add),   .rise(add_r));
  for (genvar i = 0; i < 2; i++) begin : g_sw
    rise_detect u_sw (.clk(clk), .reset(reset), .d(sw[i]), .rise(sw_r[i]));
  end
  assign run     = state == RUN_P1 || state == RUN_P2;
  assign zero    = (state == RUN_P1 && min1 == 6'd0 && sec1 == 6'd0) ||
                   (state == RUN_P2 && min2 == 6'd0 && sec2 == 6'd0);
  assign at_max  = presc == PW'(TICK_DIV - 1);
  assign tick    = run && at_max && !zero;
  assign player1 = state == RUN_P1;
  assign player2 = state == RUN_P2;
  assign setTime = state == SET;
  assign min_inc = {1'b0, min} + 7'(STEP_MIN);
  assign min_nx  = min_inc > 7'(MAX_MIN) ? 6'(STEP_MIN) : min_inc[5:0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SET;
      min      <= 6'(DEFAULT_MIN);
      moves    <= '0;
      flag     <= '0;
      presc    <= '0;
      paused_p <= P1;
      load     <= 1'b0;
    end else begin
      load <= 1'b0;
      // Pausing freezes a partial second, but a count already at its last step still wraps so the tick is not repeated on resume.
      if (run && !zero && (!start_r || at_max)) presc <= at_max ? '0 : presc + PW'(1);
      case (state)
        SET:
          if (start_r) begin
            state <= READY;
            load  <= 1'b1;
            moves <= '0;
            flag  <= '0;
            presc <= '0;
          end else if (add_r) min <= min_nx;
        READY:
          if (start_r) state <= RUN_P1;
          else if (set_r) state <= SET;
        RUN_P1:
          if (zero) begin
            state   <= FLAG;
            flag[0] <= 1'b1;
          end else if (start_r) begin
            state    <= PAUSE;
            paused_p <= P1;
          end else if (sw_r[0]) state <= RUN_P2;
        RUN_P2:
          if (zero) begin
            state   <= FLAG;
            flag[1] <= 1'b1;
          end else if (start_r) begin
            state    <= PAUSE;
            paused_p <= P2;
          end else if (sw_r[1]) begin
            state <= RUN_P1;
            moves <= moves == MOVES_MAX ? moves : moves + 8'd1;
          end
        PAUSE:
          if (start_r) state <= paused_p == P2 ? RUN_P2 : RUN_P1;
          else if (set_r) state <= SET;
        FLAG:
          if (set_r) state <= SET;
        default: state <= SET;
      endcase
    end
  end
endmodule

// File: tb/tb_chess_game_sequencer.sv
// tb_chess_game_sequencer: directed checks of the chess timer sequencer with a 4-cycle tick.
module tb_chess_game_sequencer;
  localparam logic [4:0] B_SET = 5'b00001, B_START = 5'b00010, B_ADD = 5'b00100,
                         B_SW0 = 5'b01000, B_SW1 = 5'b10000;
  logic clk, reset, set, start, add;
  logic [1:0] sw;
  logic [5:0] min1, sec1, min2, sec2, min;
  logic load, tick, player1, player2, setTime;
  logic [1:0] flag;
  logic [7:0] moves;
  int checks, errors;
  chess_game_sequencer #(.TICK_DIV(4), .DEFAULT_MIN(5), .STEP_MIN(1), .MAX_MIN(59)) dut (
    .clk(clk), .reset(reset), .set(set), .start(start), .add(add), .sw(sw),
    .min1(min1), .sec1(sec1), .min2(min2), .sec2(sec2), .min(min), .load(load),
    .tick(tick), .player1(player1), .player2(player2), .setTime(setTime),
    .flag(flag), .moves(moves)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] m);
    {sw, add, start, set} = m;
  endtask
  task automatic press(input logic [4:0] m);
    drive(m);
    cyc();
    drive(5'b0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    drive(5'b0);
    {min1, sec1, min2, sec2} = {6'd5, 6'd5, 6'd5, 6'd5};
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    check("rst_set_time", setTime, 1);
    check("rst_min", min, 5);
    check("rst_moves", moves, 0);
    check("rst_flag", flag, 0);
    check("rst_pulses", {load, tick, player1, player2}, 0);
    repeat (3) begin
      press(B_ADD);
      cyc();
    end
    check("add3_min", min, 8);
    check("add3_set_time", setTime, 1);
    press(B_START);
    check("start_load", load, 1);
    check("ready_set_time", setTime, 0);
    check("ready_p1", player1, 0);
    cyc();
    check("load_one_cycle", load, 0);
    press(B_SET);
    check("ready_to_set", setTime, 1);
    cyc();
    repeat (51) begin
      press(B_ADD);
      cyc();
    end
    check("min_max", min, 59);
    press(B_ADD);
    check("min_wrap", min, 1);
    cyc();
    press(B_ADD | B_START);
    check("add_start_min", min, 1);
    check("add_start_load", load, 1);
    check("add_start_ready", setTime, 0);
    cyc();
    press(B_START);
    check("run_p1", {player1, player2}, 2'b10);
    check("run_tick0", tick, 0);
    cyc();
    check("tick_c1", tick, 0);
    cyc();
    check("tick_c2", tick, 0);
    cyc();
    check("tick_c3", tick, 1);
    cyc();
    check("tick_wrap", tick, 0);
    press(B_SW1);
    check("sw1_ignored", {player1, player2}, 2'b10);
    cyc();
    press(B_SW0);
    check("to_p2", {player1, player2}, 2'b01);
    check("p2_tick", tick, 1);
    cyc();
    press(B_SW1);
    check("back_p1", {player1, player2}, 2'b10);
    check("moves_1", moves, 1);
    cyc();
    press(B_START);
    check("pause_players", {player1, player2}, 2'b00);
    check("pause_tick", tick, 0);
    cyc();
    check("pause_tick_hold", tick, 0);
    cyc();
    press(B_START);
    check("resume_p1", {player1, player2}, 2'b10);
    check("resume_tick0", tick, 0);
    cyc();
    check("resume_tick1", tick, 1);
    cyc();
    press(B_SET);
    check("set_in_run_ignored", {player1, setTime}, 2'b10);
    cyc();
    press(B_SW0);
    check("p2_again", player2, 1);
    check("p2_again_tick", tick, 1);
    repeat (4) cyc();
    drive(B_SW1);
    min2 = 6'd0;
    sec2 = 6'd0;
    #1;
    check("zero_tick_suppr", tick, 0);
    cyc();
    drive(5'b0);
    check("flag_p2", flag, 2'b10);
    check("flag_players", {player1, player2}, 2'b00);
    check("flag_moves", moves, 1);
    check("flag_tick", tick, 0);
    cyc();
    press(B_START);
    check("flag_start_ign", {player1, player2, setTime, load}, 4'b0000);
    cyc();
    press(B_SET);
    check("flag_to_set", setTime, 1);
    check("flag_sticky", flag, 2'b10);
    cyc();
    min2 = 6'd5;
    sec2 = 6'd5;
    press(B_START);
    check("reload_flag_clr", flag, 0);
    check("reload_moves_clr", moves, 0);
    cyc();
    press(B_START);
    cyc();
    press(B_SW0);
    cyc();
    press(B_SW1);
    cyc();
    press(B_SW0);
    check("pre_rst_p2", player2, 1);
    check("pre_rst_moves", moves, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_set_time", setTime, 1);
    check("arst_min", min, 5);
    check("arst_moves", moves, 0);
    check("arst_flag", flag, 0);
    check("arst_pulses", {load, tick, player1, player2}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
